// File: rtl/pipelined_rca_adder_if.sv
// Handshake bundle for pipelined_rca_adder: operand side (in_*) and result side (out_*).
// master = upstream/downstream environment, slave = the adder itself.
interface pipelined_rca_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );
endinterface

// File: rtl/pipelined_rca_adder.sv
// Wide adder split into SEG-bit ripple segments, one segment per pipeline stage,
// with the carry registered between stages and a valid/ready handshake on both ends.
module pipelined_rca_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    pipelined_rca_adder_if.slave bus
);
    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;
    localparam int SKEW   = (STAGES > 1) ? STAGES - 1 : 1;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] cy_q, cy_d;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic [WIDTH-1:0]  a_q   [SKEW];
    logic [WIDTH-1:0]  a_d   [SKEW];
    logic [WIDTH-1:0]  b_q   [SKEW];
    logic [WIDTH-1:0]  b_d   [SKEW];
    logic              ovf_q, ovf_d;
    logic              adv;

    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [STAGES-1:0] src_vld;
    logic [STAGES-1:0] src_cy;
    logic [SEG:0]      seg_res [STAGES];

    // Stage k consumes either the port operands (k = 0) or the registers of stage k-1.
    always_comb begin
        adv        = ~vld_q[LAST] | bus.out_ready;
        src_a[0]   = bus.a;
        src_b[0]   = bus.b;
        src_sum[0] = '0;
        src_cy[0]  = bus.cin;
        src_vld[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_sum[k] = sum_q[k-1];
            src_cy[k]  = cy_q[k-1];
            src_vld[k] = vld_q[k-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        cy_d  = cy_q;
        sum_d = sum_q;
        a_d   = a_q;
        b_d   = b_q;
        ovf_d = ovf_q;
        for (int k = 0; k < STAGES; k++) begin
            seg_res[k] = {1'b0, SEG'(src_a[k] >> (k * SEG))}
                       + {1'b0, SEG'(src_b[k] >> (k * SEG))}
                       + (SEG + 1)'(src_cy[k]);
            if (adv) begin
                vld_d[k] = src_vld[k];
                // Data only moves with a real beat, so the output holds across bubbles.
                if (src_vld[k]) begin
                    sum_d[k] = src_sum[k] | (WIDTH'(seg_res[k][SEG-1:0]) << (k * SEG));
                    cy_d[k]  = seg_res[k][SEG];
                end
            end
        end
        for (int k = 0; k < STAGES - 1; k++) begin
            if (adv && src_vld[k]) begin
                a_d[k] = src_a[k];
                b_d[k] = src_b[k];
            end
        end
        if (adv && src_vld[LAST]) begin
            ovf_d = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1])
                 && (sum_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) sum_q[k] <= '0;
            for (int k = 0; k < SKEW; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
            sum_q <= sum_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[LAST];
    assign bus.sum       = sum_q[LAST];
    assign bus.cout      = cy_q[LAST];
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder (WIDTH=16, SEG=4): directed corner beats
// plus randomized streams scored against an integer-arithmetic reference.
module tb_pipelined_rca_adder;
    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;
    localparam int LAT    = STAGES - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    pipelined_rca_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_rca_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference result {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic cin);
        longint u, s, hi, lo;
        logic   ovf;
        u   = longint'(a) + longint'(b) + longint'(cin);
        s   = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
        hi  = (longint'(1) << (WIDTH - 1)) - 1;
        lo  = -(longint'(1) << (WIDTH - 1));
        ovf = (s > hi) || (s < lo);
        return {ovf, u[WIDTH], u[WIDTH-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
    endtask

    task automatic drain();
        idle_inputs();
        bus.out_ready = 1'b1;
        repeat (STAGES + 2) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        idle_inputs();
        repeat (2) tick();
        n_checks++;
        if ({bus.out_valid, bus.overflow, bus.cout, bus.sum} !== '0)
            $display("FAIL reset_outputs: got %h required 0",
                     {bus.out_valid, bus.overflow, bus.cout, bus.sum});
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        else n_pass++;
        n_checks++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
        else n_pass++;
    endtask

    task automatic test_carry_ripple();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hFFFF;
        bus.b         = 16'h0001;
        bus.cin       = 1'b0;
        tick();
        idle_inputs();
        for (int e = 0; e < LAT; e++) begin
            n_checks++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL carry_early_valid: got %b required 0 at cycle %0d", bus.out_valid, e);
            else n_pass++;
            tick();
        end
        n_checks++;
        if ({bus.out_valid, bus.overflow, bus.cout, bus.sum} !== {1'b1, 1'b0, 1'b1, 16'h0000})
            $display("FAIL carry_result: got %h required %h",
                     {bus.out_valid, bus.overflow, bus.cout, bus.sum}, {1'b1, 1'b0, 1'b1, 16'h0000});
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.out_valid, bus.overflow, bus.cout, bus.sum} !== {1'b0, 1'b0, 1'b1, 16'h0000})
            $display("FAIL carry_bubble_hold: got %h required %h",
                     {bus.out_valid, bus.overflow, bus.cout, bus.sum}, {1'b0, 1'b0, 1'b1, 16'h0000});
        else n_pass++;
        drain();
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.a = 16'h7FFF; bus.b = 16'h0001; bus.cin = 1'b0;
        tick();
        bus.a = 16'h8000; bus.b = 16'h8000; bus.cin = 1'b1;
        tick();
        idle_inputs();
        repeat (LAT - 1) tick();
        n_checks++;
        if ({bus.out_valid, bus.overflow, bus.cout, bus.sum} !== {1'b1, 1'b1, 1'b0, 16'h8000})
            $display("FAIL ovf_pos: got %h required %h",
                     {bus.out_valid, bus.overflow, bus.cout, bus.sum}, {1'b1, 1'b1, 1'b0, 16'h8000});
        else n_pass++;
        tick();
        n_checks++;
        if ({bus.out_valid, bus.overflow, bus.cout, bus.sum} !== {1'b1, 1'b1, 1'b1, 16'h0001})
            $display("FAIL ovf_neg: got %h required %h",
                     {bus.out_valid, bus.overflow, bus.cout, bus.sum}, {1'b1, 1'b1, 1'b1, 16'h0001});
        else n_pass++;
        drain();
    endtask

    // Streams n offered beats (one every vper cycles), out_ready high with rpct percent.
    task automatic run_stream(input string name, input int n, input int vper,
                              input int rpct, input bit vecs);
        logic [WIDTH+1:0] exp_q[$];
        logic [WIDTH+1:0] expv, snap;
        bit               acc_hist[$];
        bit               stalled, hold, exp_vld;
        logic [WIDTH-1:0] va[4];
        logic [WIDTH-1:0] vb[4];
        va = '{16'h000C, 16'h000E, 16'h000F, 16'h0009};
        vb = '{16'h0003, 16'h000D, 16'h000F, 16'h000F};
        hold = 1'b0;
        for (int i = 0; i < n + 40; i++) begin
            if (!hold) begin
                bus.in_valid = (i < n) && (i % vper == 0);
                if (vecs && i < 4) begin
                    bus.a = va[i]; bus.b = vb[i]; bus.cin = 1'b0;
                end else begin
                    bus.a   = WIDTH'($urandom);
                    bus.b   = WIDTH'($urandom);
                    bus.cin = 1'($urandom_range(1));
                end
            end
            bus.out_ready = (rpct >= 100) ? 1'b1 : (int'($urandom_range(99)) < rpct);
            #1;
            n_checks++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready))
                $display("FAIL %s_in_ready: got %b required %b at cycle %0d", name, bus.in_ready,
                         !(bus.out_valid && !bus.out_ready), i);
            else n_pass++;
            snap    = {bus.overflow, bus.cout, bus.sum};
            stalled = bus.out_valid && !bus.out_ready;
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s_extra: got %h required no result at cycle %0d", name, snap, i);
                end else begin
                    expv = exp_q.pop_front();
                    if (snap !== expv)
                        $display("FAIL %s_data: got %h required %h at cycle %0d", name, snap, expv, i);
                    else n_pass++;
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_add(bus.a, bus.b, bus.cin));
            acc_hist.push_back(bus.in_valid && bus.in_ready);
            hold = bus.in_valid && !bus.in_ready;
            tick();
            if (stalled) begin
                n_checks++;
                if ({bus.out_valid, bus.overflow, bus.cout, bus.sum} !== {1'b1, snap})
                    $display("FAIL %s_stall_hold: got %h required %h at cycle %0d", name,
                             {bus.out_valid, bus.overflow, bus.cout, bus.sum}, {1'b1, snap}, i);
                else n_pass++;
            end
            if (rpct >= 100) begin
                exp_vld = (i >= LAT) ? acc_hist[i-LAT] : 1'b0;
                n_checks++;
                if (bus.out_valid !== exp_vld)
                    $display("FAIL %s_valid_pattern: got %b required %b at cycle %0d", name,
                             bus.out_valid, exp_vld, i);
                else n_pass++;
            end
        end
        idle_inputs();
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: got %0d results outstanding required 0", name, exp_q.size());
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        run_stream("back_to_back", 200, 1, 100, 1'b1);
    endtask

    task automatic test_backpressure();
        run_stream("backpressure", 300, 1, 50, 1'b0);
    endtask

    task automatic test_sparse();
        run_stream("sparse", 60, 3, 100, 1'b0);
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.a        = WIDTH'($urandom);
            bus.b        = WIDTH'($urandom);
            bus.cin      = 1'($urandom_range(1));
            tick();
        end
        idle_inputs();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({bus.out_valid, bus.overflow, bus.cout, bus.sum} !== '0)
            $display("FAIL midreset_outputs: got %h required 0",
                     {bus.out_valid, bus.overflow, bus.cout, bus.sum});
        else n_pass++;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL midreset_stale: got %b required 0 at cycle %0d", bus.out_valid, k);
            else n_pass++;
        end
        bus.in_valid = 1'b1;
        bus.a = 16'h1234; bus.b = 16'h4321; bus.cin = 1'b0;
        tick();
        idle_inputs();
        repeat (LAT) tick();
        n_checks++;
        if ({bus.out_valid, bus.overflow, bus.cout, bus.sum} !== {1'b1, 1'b0, 1'b0, 16'h5555})
            $display("FAIL midreset_fresh: got %h required %h",
                     {bus.out_valid, bus.overflow, bus.cout, bus.sum}, {1'b1, 1'b0, 1'b0, 16'h5555});
        else n_pass++;
        drain();
    endtask

    initial begin
        idle_inputs();
        bus.out_ready = 1'b0;
        test_reset();
        test_carry_ripple();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
